// File: rtl/pulpino_banked_mem.sv
// Word-interleaved multi-port SRAM: NUM_PORTS masters share NUM_BANKS single-port banks.
// Define PULPINO_MEM_RR_ARB_EN for per-bank round-robin arbitration; otherwise the lowest requesting port wins.
module pulpino_banked_mem #(
  parameter int NUM_PORTS  = 2,
  parameter int NUM_BANKS  = 4,
  parameter int BANK_WORDS = 2048,
  parameter int DATA_WIDTH = 32,
  localparam int ADDR_WIDTH = $clog2(NUM_BANKS * BANK_WORDS),
  localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             port_req_i,
  output logic [NUM_PORTS-1:0]             port_gnt_o,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_addr_i,
  input  logic [NUM_PORTS-1:0]             port_we_i,
  input  logic [NUM_PORTS*BE_WIDTH-1:0]    port_be_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_wdata_i,
  output logic [NUM_PORTS-1:0]             port_rvalid_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  port_rdata_o
);

  localparam int BANK_SEL_W = $clog2(NUM_BANKS);
  localparam int BANK_IDX_W = (NUM_BANKS > 1) ? BANK_SEL_W : 1;
  localparam int ROW_W      = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;
  localparam int PORT_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  function automatic logic [PORT_W-1:0] wrap_port(input int idx);
    return PORT_W'(idx % NUM_PORTS);
  endfunction

  logic [BANK_IDX_W-1:0] port_bank  [NUM_PORTS];
  logic [ROW_W-1:0]      port_row   [NUM_PORTS];
  logic [PORT_W-1:0]     arb_start  [NUM_BANKS];
  logic [PORT_W-1:0]     bank_win   [NUM_BANKS];
  logic [NUM_BANKS-1:0]  bank_act;
  logic [NUM_BANKS-1:0]  bank_we;
  logic [ROW_W-1:0]      bank_row   [NUM_BANKS];
  logic [BE_WIDTH-1:0]   bank_be    [NUM_BANKS];
  logic [DATA_WIDTH-1:0] bank_wdata [NUM_BANKS];
  logic [DATA_WIDTH-1:0] bank_rword [NUM_BANKS];

  // Low address bits pick the bank so consecutive words land in consecutive banks.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_bank[p] = (NUM_BANKS > 1) ? port_addr_i[p*ADDR_WIDTH +: BANK_IDX_W] : '0;
      port_row[p]  = ROW_W'(port_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH] >> BANK_SEL_W);
    end
  end

  // NOTE: every output of a combinational block gets a default before any branch, so no latch is inferred.
  always_comb begin
    logic [PORT_W-1:0] cand;
    cand       = '0;
    port_gnt_o = '0;
    bank_act   = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_win[b] = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        cand = wrap_port(int'(arb_start[b]) + k);
        if (!rst && !bank_act[b] && port_req_i[cand] && port_bank[cand] == BANK_IDX_W'(b)) begin
          bank_act[b]      = 1'b1;
          bank_win[b]      = cand;
          port_gnt_o[cand] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_row[b]   = port_row[bank_win[b]];
      bank_we[b]    = port_we_i[bank_win[b]];
      bank_be[b]    = port_be_i[bank_win[b]*BE_WIDTH +: BE_WIDTH];
      bank_wdata[b] = port_wdata_i[bank_win[b]*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef PULPINO_MEM_RR_ARB_EN
  logic [PORT_W-1:0] rr_q [NUM_BANKS];
  logic [PORT_W-1:0] rr_d [NUM_BANKS];

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++)
      rr_d[b] = bank_act[b] ? wrap_port(int'(bank_win[b]) + 1) : rr_q[b];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) rr_q[b] <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

  assign arb_start = rr_q;
`else
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) arb_start[b] = '0;
  end
`endif

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [BANK_WORDS];

    // NOTE: the RAM array has no reset, so it maps onto plain SRAM macros and keeps contents across rst.
    always_ff @(posedge clk) begin
      if (bank_act[b] && bank_we[b]) begin
        for (int i = 0; i < BE_WIDTH; i++)
          if (bank_be[b][i]) mem[bank_row[b]][i*8 +: 8] <= bank_wdata[b][i*8 +: 8];
      end
    end

    assign bank_rword[b] = mem[bank_row[b]];
  end

  logic [NUM_PORTS-1:0]  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q [NUM_PORTS];

  // Writes answer with zero data; the last response is held until the next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= '0;
      for (int p = 0; p < NUM_PORTS; p++) rdata_q[p] <= '0;
    end else begin
      rvalid_q <= port_gnt_o;
      for (int p = 0; p < NUM_PORTS; p++)
        if (port_gnt_o[p]) rdata_q[p] <= port_we_i[p] ? '0 : bank_rword[port_bank[p]];
    end
  end

  assign port_rvalid_o = rvalid_q;
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rdata
    assign port_rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = rdata_q[p];
  end

endmodule

// File: tb/tb_pulpino_banked_mem.sv
// Self-checking bench for pulpino_banked_mem: directed scenarios plus randomized traffic
// compared against a word-array reference model that follows the arbitration rules.
module tb_pulpino_banked_mem;
  localparam int NP  = 2;
  localparam int NB  = 4;
  localparam int AW  = 13;
  localparam int DW  = 32;
  localparam int BEW = DW / 8;
`ifdef PULPINO_MEM_RR_ARB_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     port_req_i;
  logic [NP-1:0]     port_gnt_o;
  logic [NP*AW-1:0]  port_addr_i;
  logic [NP-1:0]     port_we_i;
  logic [NP*BEW-1:0] port_be_i;
  logic [NP*DW-1:0]  port_wdata_i;
  logic [NP-1:0]     port_rvalid_o;
  logic [NP*DW-1:0]  port_rdata_o;

  pulpino_banked_mem #(
    .NUM_PORTS(NP), .NUM_BANKS(NB), .BANK_WORDS(2048), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .port_req_i(port_req_i), .port_gnt_o(port_gnt_o),
    .port_addr_i(port_addr_i), .port_we_i(port_we_i),
    .port_be_i(port_be_i), .port_wdata_i(port_wdata_i),
    .port_rvalid_o(port_rvalid_o), .port_rdata_o(port_rdata_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [NP-1:0]   req_s, we_s;
  int              addr_s [NP];
  logic [BEW-1:0]  be_s   [NP];
  logic [DW-1:0]   wd_s   [NP];
  logic [DW-1:0]   mem_m  [int];
  logic [DW-1:0]   exp_rd [NP];
  int              rr_m   [NB];
  logic [NP-1:0]   last_gnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic r, input int a, input logic w,
                          input logic [BEW-1:0] be, input logic [DW-1:0] d);
    req_s[p] = r; addr_s[p] = a; we_s[p] = w; be_s[p] = be; wd_s[p] = d;
    port_req_i[p]               = r;
    port_addr_i[p*AW +: AW]     = AW'(a);
    port_we_i[p]                = w;
    port_be_i[p*BEW +: BEW]     = be;
    port_wdata_i[p*DW +: DW]    = d;
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++) rr_m[b] = 0;
    for (int p = 0; p < NP; p++) exp_rd[p] = '0;
  endtask

  // One access cycle: check grants mid-cycle, then responses just after the edge.
  task automatic do_cycle();
    int            win [NB];
    int            start, p;
    logic [NP-1:0] eg;
    logic [DW-1:0] word;
    @(negedge clk);
    eg = '0;
    for (int b = 0; b < NB; b++) begin
      win[b] = -1;
      start  = RR_EN ? rr_m[b] : 0;
      for (int k = 0; k < NP; k++) begin
        p = (start + k) % NP;
        if (win[b] < 0 && req_s[p] && (addr_s[p] % NB) == b) win[b] = p;
      end
      if (win[b] >= 0) eg[win[b]] = 1'b1;
    end
    chk("gnt", 64'(port_gnt_o), 64'(eg));
    last_gnt = port_gnt_o;
    @(posedge clk);
    #1;
    for (int q = 0; q < NP; q++)
      if (eg[q] && !we_s[q]) exp_rd[q] = mem_m[addr_s[q]];
    for (int q = 0; q < NP; q++)
      if (eg[q] && we_s[q]) begin
        word = mem_m.exists(addr_s[q]) ? mem_m[addr_s[q]] : '0;
        for (int i = 0; i < BEW; i++)
          if (be_s[q][i]) word[i*8 +: 8] = wd_s[q][i*8 +: 8];
        mem_m[addr_s[q]] = word;
        exp_rd[q] = '0;
      end
    for (int b = 0; b < NB; b++)
      if (win[b] >= 0) rr_m[b] = (win[b] + 1) % NP;
    chk("rvalid", 64'(port_rvalid_o), 64'(eg));
    chk("rdata", 64'(port_rdata_o), {exp_rd[1], exp_rd[0]});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] seq;
    rst = 1'b1;
    set_port(0, 1'b1, 0, 1'b0, 4'hF, '0);
    set_port(1, 1'b1, 1, 1'b0, 4'hF, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 64'(port_gnt_o), 64'(0));
    chk("rst_rvalid", 64'(port_rvalid_o), 64'(0));
    chk("rst_rdata", 64'(port_rdata_o), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Both ports hammer bank 0 for four cycles.
    set_port(0, 1'b1, 4, 1'b1, 4'hF, 32'h0404_0404);
    set_port(1, 1'b1, 8, 1'b1, 4'hF, 32'h0808_0808);
    for (int k = 0; k < 4; k++) begin
      do_cycle();
      seq[k] = last_gnt[0];
    end
    chk("conflict_pattern", 64'(seq), RR_EN ? 64'h5 : 64'hF);

    // Fill the working set so no read returns an unwritten word.
    set_port(1, 1'b0, 0, 1'b0, 4'h0, '0);
    for (int a = 0; a < 32; a++) begin
      set_port(0, 1'b1, a, 1'b1, 4'hF, $urandom);
      do_cycle();
    end

    set_port(0, 1'b1, 5, 1'b1, 4'hF, 32'hDEAD_BEEF);
    do_cycle();
    chk("wr_resp_zero", 64'(port_rdata_o[31:0]), 64'(0));
    set_port(0, 1'b1, 5, 1'b0, 4'hF, '0);
    do_cycle();
    chk("rd_rvalid", 64'(port_rvalid_o[0]), 64'(1));
    chk("rd_deadbeef", 64'(port_rdata_o[31:0]), 64'hDEAD_BEEF);

    set_port(0, 1'b1, 8, 1'b1, 4'hF, 32'h1122_3344);
    do_cycle();
    set_port(0, 1'b1, 8, 1'b1, 4'b0101, 32'hAABB_CCDD);
    do_cycle();
    set_port(0, 1'b1, 8, 1'b0, 4'h0, '0);
    do_cycle();
    chk("byte_enable", 64'(port_rdata_o[31:0]), 64'h11BB_33DD);

    set_port(0, 1'b1, 0, 1'b0, 4'h0, '0);
    set_port(1, 1'b1, 1, 1'b0, 4'h0, '0);
    do_cycle();
    chk("parallel_gnt", 64'(last_gnt), 64'h3);
    chk("parallel_rvalid", 64'(port_rvalid_o), 64'h3);

    // Randomized traffic on words 16..31, including same-bank and same-address collisions.
    for (int n = 0; n < 300; n++) begin
      for (int p = 0; p < NP; p++)
        set_port(p, $urandom_range(0, 3) != 0, $urandom_range(16, 31),
                 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
      do_cycle();
    end

    // Write just before reset: the response is dropped but the data stays.
    set_port(1, 1'b0, 0, 1'b0, 4'h0, '0);
    set_port(0, 1'b1, 3, 1'b1, 4'hF, 32'hCAFE_F00D);
    do_cycle();
    rst = 1'b1;
    #1;
    chk("rst_drop_rvalid", 64'(port_rvalid_o), 64'(0));
    chk("rst_drop_rdata", 64'(port_rdata_o), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Read granted combinationally, then reset lands before the edge.
    set_port(0, 1'b1, 5, 1'b0, 4'h0, '0);
    @(negedge clk);
    chk("midread_gnt", 64'(port_gnt_o), 64'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("midread_gnt_rst", 64'(port_gnt_o), 64'(0));
    @(posedge clk);
    #1;
    chk("midread_no_rvalid", 64'(port_rvalid_o), 64'(0));
    rst = 1'b0;
    model_reset();

    do_cycle();
    chk("retained_deadbeef", 64'(port_rdata_o[31:0]), 64'hDEAD_BEEF);
    set_port(0, 1'b1, 3, 1'b0, 4'h0, '0);
    do_cycle();
    chk("retained_cafef00d", 64'(port_rdata_o[31:0]), 64'hCAFE_F00D);

    set_port(0, 1'b0, 0, 1'b0, 4'h0, '0);
    do_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulpino_banked_mem.md
# pulpino_banked_mem

Multi-port, word-interleaved banked SRAM subsystem for the PULPino memory domain, generalising the fixed single-instruction/single-data memory pair to `NUM_PORTS` masters sharing `NUM_BANKS` single-port banks. Each bank runs per-bank arbitration with a request/grant handshake and returns read data one cycle after grant. It sits between the core/AXI memory-side adapters and the physical RAM, so masters hitting different banks proceed in parallel.

## Interface
- `NUM_PORTS`, 2: number of master ports; ≥1.
- `NUM_BANKS`, 4: number of banks; power of two, ≥1.
- `BANK_WORDS`, 2048: words per bank; power of two.
- `DATA_WIDTH`, 32: word width; multiple of 8.
- `ADDR_WIDTH` (localparam): `$clog2(NUM_BANKS*BANK_WORDS)`, word address width.
- `clk` in 1: sole clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `port_req_i` in NUM_PORTS: per-port access request.
- `port_gnt_o` out NUM_PORTS: per-port grant, combinational from the current request and arbiter state.
- `port_addr_i` in NUM_PORTS*ADDR_WIDTH: word address, port p at slice [p*ADDR_WIDTH +: ADDR_WIDTH].
- `port_we_i` in NUM_PORTS: 1 = write, 0 = read.
- `port_be_i` in NUM_PORTS*DATA_WIDTH/8: byte enables for writes.
- `port_wdata_i` in NUM_PORTS*DATA_WIDTH: write data.
- `port_rvalid_o` out NUM_PORTS: response strobe, one pulse per granted request.
- `port_rdata_o` out NUM_PORTS*DATA_WIDTH: read data, valid with `port_rvalid_o`.

## Operation
- Bank index = addr[$clog2(NUM_BANKS)-1:0]; row = remaining upper bits. Consecutive words map to consecutive banks.
- Each bank grants at most one port per cycle. Each port receives at most one grant per cycle, because it presents one address.
- Arbitration: per-bank round-robin pointer `rr[b]`. Search starts at port `rr[b]` and wraps. After a grant to port p, `rr[b]` <= (p+1) mod NUM_PORTS. The pointer does not change when the bank grants nobody.
- Granted write: bytes with be=1 are updated at the grant edge; bytes with be=0 are unchanged. be=0 overall is a legal no-op that still completes.
- Granted read: row contents are registered into that port's rdata at the grant edge.
- Response: `port_rvalid_o[p]` is high in the cycle after every grant, for reads and writes. `port_rdata_o[p]` is the read word for reads and all-zero for writes. The value holds until the next response.
- Masters keep req/addr/we/be/wdata stable until gnt. The block does not need this for correctness; it arbitrates the values present each cycle.
- A read and a write to the same address in the same cycle are serialized by the bank arbiter. The read returns the value from before or after the write according to grant order.
- Memory contents are not reset.

## Timing
- Reset values: `port_rvalid_o`=0, `port_rdata_o`=0, all `rr[b]`=0. `port_gnt_o` is 0 while `rst` is high, regardless of requests.
- Latency: grant in cycle N (same cycle as req when uncontended) -> rvalid/rdata in cycle N+1. Throughput is 1 access/cycle/bank.
- Back-to-back grants to one port produce back-to-back rvalid pulses.
- Reset asserted mid-operation: any pending response is dropped (rvalid forced to 0 immediately). Writes granted at the last edge before reset are retained.
- With NUM_PORTS=1 the arbiter degenerates: gnt = req.

## Configuration
- `PULPINO_MEM_RR_ARB_EN` defined: round-robin arbitration as described above.
- Not defined: fixed priority, lowest-index requesting port always wins. `rr[b]` registers are not instantiated. All other behaviour is identical.

## Test plan
- Reset: assert `rst` with all req=1 -> all gnt=0, rvalid=0, rdata=0. Deassert -> grants resume next cycle.
- Single port: write 0xDEADBEEF to addr 5 with be=4'b1111, then read addr 5 -> gnt same cycle each time. Read rvalid one cycle later with rdata=0xDEADBEEF. Write response rdata=0.
- Byte enables: write 0x11223344 to addr 8, then write 0xAABBCCDD with be=4'b0101 -> read returns 0x11BB33DD.
- Parallel banks (NUM_BANKS=4): port0 reads addr 0 while port1 reads addr 1, same cycle -> both granted, both rvalid next cycle.
- Conflict, round-robin: ports 0 and 1 hold req to addr 4 and addr 8 (both bank 0) for 4 cycles -> grants alternate 0,1,0,1. Without the macro -> port0 granted all 4 cycles.
- Reset mid-read: grant a read, assert `rst` before the next edge -> no rvalid pulse. Memory written earlier is still readable after reset.
